// File: rtl/pc_stack_unit.sv
// Program counter with a circular return-address stack for the fetch path.
// Supports increment, branch, call and return with a memory-stall freeze and sticky stack error flags.
module pc_stack_unit #(
    parameter int                ADDR_W      = 16,
    parameter int                STEP        = 1,
    parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
    parameter int                STACK_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           mem_ready,
    input  logic                           branch_en,
    input  logic [ADDR_W-1:0]              branch_addr,
    input  logic                           call_en,
    input  logic [ADDR_W-1:0]              call_addr,
    input  logic                           ret_en,
    input  logic                           clr_err,
    output logic [ADDR_W-1:0]              pc_current,
    output logic [$clog2(STACK_DEPTH):0]   stack_count,
    output logic                           stack_overflow,
    output logic                           stack_underflow
);

    localparam int                PTR_W  = $clog2(STACK_DEPTH);
    localparam int                CNT_W  = PTR_W + 1;
    localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);
    localparam logic [CNT_W-1:0]  FULL   = CNT_W'(STACK_DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d, seq_pc;
    logic [PTR_W-1:0]  ptr_q, ptr_d, top_ptr;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              push, ovf_ev, unf_ev;
    logic [ADDR_W-1:0] mem_q [STACK_DEPTH];

    always_comb begin
        seq_pc  = pc_q + STEP_V;
        top_ptr = ptr_q - PTR_W'(1);
        pc_d    = pc_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        ovf_ev  = 1'b0;
        unf_ev  = 1'b0;
        if (mem_ready) begin
            if (ret_en) begin
                if (cnt_q != '0) begin
                    pc_d  = mem_q[top_ptr];
                    ptr_d = top_ptr;
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    pc_d   = seq_pc;
                    unf_ev = 1'b1;
                end
            end else if (call_en) begin
                // When full, the write pointer already sits on the oldest entry.
                push  = 1'b1;
                pc_d  = call_addr;
                ptr_d = ptr_q + PTR_W'(1);
                if (cnt_q == FULL) begin
                    ovf_ev = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (branch_en) begin
                pc_d = branch_addr;
            end else begin
                pc_d = seq_pc;
            end
        end
        ovf_d = (ovf_q & ~clr_err) | ovf_ev;
        unf_d = (unf_q & ~clr_err) | unf_ev;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q  <= RESET_VEC;
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Storage is deliberately unreset; the count guards against reading stale entries.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[ptr_q] <= seq_pc;
        end
    end

    assign pc_current      = pc_q;
    assign stack_count     = cnt_q;
    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench for pc_stack_unit: directed vector table, async reset sequence,
// then randomized traffic against a queue-based reference model.
module tb_pc_stack_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_ready = 1'b0;
    logic        branch_en = 1'b0;
    logic [15:0] branch_addr = '0;
    logic        call_en = 1'b0;
    logic [15:0] call_addr = '0;
    logic        ret_en = 1'b0;
    logic        clr_err = 1'b0;
    logic [15:0] pc_current;
    logic [2:0]  stack_count;
    logic        stack_overflow;
    logic        stack_underflow;

    int total = 0;
    int bad   = 0;

    pc_stack_unit #(.ADDR_W(16), .STEP(1), .RESET_VEC(16'h0000), .STACK_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .mem_ready(mem_ready),
        .branch_en(branch_en), .branch_addr(branch_addr),
        .call_en(call_en), .call_addr(call_addr),
        .ret_en(ret_en), .clr_err(clr_err),
        .pc_current(pc_current), .stack_count(stack_count),
        .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mr; int br; int ba; int ce; int ca; int rt; int clr;
        int pc; int cnt; int ovf; int unf;
    } vec_t;

    vec_t tbl[$];

    // Reference model state: plain PC and a queue whose back is the stack top.
    logic [15:0] m_pc;
    logic [15:0] m_stk[$];
    logic        m_ovf, m_unf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0] pc, input int cnt,
                             input logic ovf, input logic unf);
        chk({tag, " pc"}, 32'(pc_current), 32'(pc));
        chk({tag, " count"}, 32'(stack_count), 32'(cnt));
        chk({tag, " ovf"}, 32'(stack_overflow), 32'(ovf));
        chk({tag, " unf"}, 32'(stack_underflow), 32'(unf));
    endtask

    task automatic drive(input int mr, input int br, input int ba, input int ce,
                         input int ca, input int rt, input int clr);
        mem_ready   = mr[0];
        branch_en   = br[0];
        branch_addr = 16'(ba);
        call_en     = ce[0];
        call_addr   = 16'(ca);
        ret_en      = rt[0];
        clr_err     = clr[0];
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_step;
        logic ovf_ev, unf_ev;
        ovf_ev = 1'b0;
        unf_ev = 1'b0;
        if (mem_ready) begin
            if (ret_en) begin
                if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                else begin
                    m_pc   = m_pc + 16'd1;
                    unf_ev = 1'b1;
                end
            end else if (call_en) begin
                m_stk.push_back(m_pc + 16'd1);
                if (m_stk.size() > 4) begin
                    void'(m_stk.pop_front());
                    ovf_ev = 1'b1;
                end
                m_pc = call_addr;
            end else if (branch_en) begin
                m_pc = branch_addr;
            end else begin
                m_pc = m_pc + 16'd1;
            end
        end
        m_ovf = (m_ovf && !clr_err) || ovf_ev;
        m_unf = (m_unf && !clr_err) || unf_ev;
    endtask

    initial begin
        //             mr br ba       ce ca       rt clr  pc       cnt ovf unf
        tbl.push_back('{1, 0, 'h0000, 0, 'h0000, 0, 0, 'h0001, 0, 0, 0});
        tbl.push_back('{1, 0, 'h0000, 0, 'h0000, 0, 0, 'h0002, 0, 0, 0});
        tbl.push_back('{1, 0, 'h0000, 1, 'h1000, 0, 0, 'h1000, 1, 0, 0});
        tbl.push_back('{1, 0, 'h0000, 0, 'h0000, 0, 0, 'h1001, 1, 0, 0});
        tbl.push_back('{1, 0, 'h0000, 0, 'h0000, 0, 0, 'h1002, 1, 0, 0});
        tbl.push_back('{1, 0, 'h0000, 0, 'h0000, 1, 0, 'h0003, 0, 0, 0});
        tbl.push_back('{0, 0, 'h0000, 1, 'h5555, 0, 0, 'h0003, 0, 0, 0});
        tbl.push_back('{0, 0, 'h0000, 1, 'h5555, 0, 0, 'h0003, 0, 0, 0});
        tbl.push_back('{1, 0, 'h0000, 0, 'h0000, 0, 0, 'h0004, 0, 0, 0});
        tbl.push_back('{1, 1, 'h0000, 0, 'h0000, 0, 0, 'h0000, 0, 0, 0});
        tbl.push_back('{1, 0, 'h0000, 1, 'h0100, 0, 0, 'h0100, 1, 0, 0});
        tbl.push_back('{1, 0, 'h0000, 1, 'h0200, 0, 0, 'h0200, 2, 0, 0});
        tbl.push_back('{1, 0, 'h0000, 1, 'h0300, 0, 0, 'h0300, 3, 0, 0});
        tbl.push_back('{1, 0, 'h0000, 1, 'h0400, 0, 0, 'h0400, 4, 0, 0});
        tbl.push_back('{1, 0, 'h0000, 1, 'h0500, 0, 0, 'h0500, 4, 1, 0});
        tbl.push_back('{1, 0, 'h0000, 0, 'h0000, 1, 0, 'h0401, 3, 1, 0});
        tbl.push_back('{1, 0, 'h0000, 0, 'h0000, 1, 0, 'h0301, 2, 1, 0});
        tbl.push_back('{1, 0, 'h0000, 0, 'h0000, 1, 0, 'h0201, 1, 1, 0});
        tbl.push_back('{1, 0, 'h0000, 0, 'h0000, 1, 0, 'h0101, 0, 1, 0});
        tbl.push_back('{1, 0, 'h0000, 0, 'h0000, 1, 0, 'h0102, 0, 1, 1});
        tbl.push_back('{0, 0, 'h0000, 0, 'h0000, 0, 1, 'h0102, 0, 0, 0});
        tbl.push_back('{1, 1, 'hFFFF, 0, 'h0000, 0, 0, 'hFFFF, 0, 0, 0});
        tbl.push_back('{1, 0, 'h0000, 0, 'h0000, 0, 0, 'h0000, 0, 0, 0});
        tbl.push_back('{1, 1, 'hFFFF, 0, 'h0000, 0, 0, 'hFFFF, 0, 0, 0});
        tbl.push_back('{1, 0, 'h0000, 1, 'h2000, 0, 0, 'h2000, 1, 0, 0});
        tbl.push_back('{1, 1, 'h4000, 1, 'h3000, 1, 0, 'h0000, 0, 0, 0});
        tbl.push_back('{1, 0, 'h0000, 0, 'h0000, 1, 1, 'h0001, 0, 0, 1});
        tbl.push_back('{1, 0, 'h0000, 0, 'h0000, 0, 1, 'h0002, 0, 0, 0});
        tbl.push_back('{1, 0, 'h0000, 1, 'h0050, 0, 0, 'h0050, 1, 0, 0});
        tbl.push_back('{1, 0, 'h0000, 0, 'h0000, 1, 0, 'h0003, 0, 0, 0});

        // Reset held across two edges.
        drive(1, 0, 0, 1, 'h7777, 0, 0);
        tick;
        check_all("reset edge1", 16'h0000, 0, 1'b0, 1'b0);
        tick;
        check_all("reset edge2", 16'h0000, 0, 1'b0, 1'b0);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].mr, tbl[i].br, tbl[i].ba, tbl[i].ce, tbl[i].ca, tbl[i].rt, tbl[i].clr);
            tick;
            check_all($sformatf("vec%0d", i), 16'(tbl[i].pc), tbl[i].cnt,
                      tbl[i].ovf[0], tbl[i].unf[0]);
        end

        // Asynchronous reset between edges with a populated stack and a set flag.
        drive(1, 0, 0, 0, 0, 1, 0);
        tick;
        check_all("pre-rst underflow", 16'h0004, 0, 1'b0, 1'b1);
        drive(1, 0, 0, 1, 'h1000, 0, 0);
        tick;
        drive(1, 0, 0, 1, 'h1234, 0, 0);
        tick;
        check_all("pre-rst state", 16'h1234, 2, 1'b0, 1'b1);
        drive(0, 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b0;
        #1;
        check_all("async rst", 16'h0000, 0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        drive(1, 0, 0, 0, 0, 1, 0);
        tick;
        check_all("post-rst ret", 16'h0001, 0, 1'b0, 1'b1);

        // Randomized traffic against the model.
        m_pc = 16'h0001;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b1;
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 3) != 0) ? 1 : 0,
                  ($urandom_range(0, 2) == 0) ? 1 : 0, int'($urandom_range(0, 16'hFFFF)),
                  ($urandom_range(0, 2) == 0) ? 1 : 0, int'($urandom_range(0, 16'hFFFF)),
                  ($urandom_range(0, 3) == 0) ? 1 : 0,
                  ($urandom_range(0, 9) == 0) ? 1 : 0);
            model_step;
            tick;
            check_all($sformatf("rand%0d", n), m_pc, m_stk.size(), m_ovf, m_unf);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_stack_unit.md
# pc_stack_unit

Parametrised program counter with a hardware return-address stack, successor to the fixed 16-bit program counter in the fetch path. Adds call/return on top of increment, branch and memory-stall freeze. Also adds configurable address width, increment step, reset vector and stack depth, with sticky overflow/underflow error flags. Sits between the decoder (branch/call/ret requests) and instruction memory (`pc_current` is the fetch address).

## Interface

- `ADDR_W`, 16, PC and address width in bits (>= 4).
- `STEP`, 1, increment added per sequential fetch (1..2^ADDR_W-1).
- `RESET_VEC`, 0, PC value loaded by reset.
- `STACK_DEPTH`, 4, return stack entries (power of two, >= 2).

- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `mem_ready`  in  1  1 = fetch accepted, PC may advance; 0 = freeze.
- `branch_en`  in  1  jump request.
- `branch_addr`  in  ADDR_W  jump target.
- `call_en`  in  1  call request.
- `call_addr`  in  ADDR_W  call target.
- `ret_en`  in  1  return request.
- `clr_err`  in  1  clears sticky error flags.
- `pc_current`  out  ADDR_W  registered fetch address.
- `stack_count`  out  log2(STACK_DEPTH)+1  valid entries, 0..STACK_DEPTH.
- `stack_overflow`  out  1  sticky: call issued while stack full.
- `stack_underflow`  out  1  sticky: return issued while stack empty.

## Operation

- Stack: circular buffer of STACK_DEPTH entries, write pointer plus saturating count.
- Requests are sampled only on an edge with `mem_ready`=1. With `mem_ready`=0, PC, stack, pointer and count all hold. Requests are dropped, not queued.
- Priority when several requests are high: `ret_en` > `call_en` > `branch_en` > increment.
- Increment: PC <= PC + STEP, modulo 2^ADDR_W.
- Branch: PC <= `branch_addr`; stack untouched.
- Call: push (PC + STEP) mod 2^ADDR_W, then PC <= `call_addr`.
  - If count = STACK_DEPTH: oldest entry is overwritten, count stays STACK_DEPTH, `stack_overflow` set.
- Return with count > 0: PC <= top entry, pointer decrements (wraps), count - 1.
- Return with count = 0: treated as increment; `stack_underflow` set, stack unchanged.
- Error flags are sticky until `clr_err` or reset.
  - `clr_err` acts on any edge regardless of `mem_ready`.
  - If a new error event and `clr_err` occur on the same edge, the flag ends 1.
- Stack storage contents are not reset; only pointer and count are. Unwritten entries are never returned.

## Timing

- Reset (`rst`=0) acts immediately, independent of `clk`:
  - `pc_current` = RESET_VEC
  - `stack_count` = 0, pointer = 0
  - both flags = 0
- Reset held: outputs stay at reset values. First update on the first rising edge with `rst`=1.
- Latency: request sampled at edge N; new `pc_current` and `stack_count` visible after edge N. No combinational path from inputs to outputs.
- Call then return on consecutive edges is legal. The return pops the address pushed one edge earlier.
- Reset asserted mid-stall or mid-call sequence discards all stack state.

## Test plan

All scenarios use ADDR_W=16, STEP=1, RESET_VEC=0000, STACK_DEPTH=4.

1. `rst`=0 for 2 edges, then `rst`=1 with `mem_ready`=1 -> `pc_current` 0000 during reset, then 0001, 0002.
2. At PC 0002, `call_en`=1, `call_addr`=1000 -> PC 1000, count 1. Two increments -> 1002. `ret_en` -> PC 0003, count 0.
3. `mem_ready`=0 with `call_en`=1 for 2 edges -> PC and count unchanged. Then `mem_ready`=1 with no request -> PC+1.
4. From PC 0000, five calls to 0100, 0200, 0300, 0400, 0500:
   - Result: count 4, `stack_overflow`=1.
   - Four returns -> 0401, 0301, 0201, 0101.
   - Fifth return -> PC 0102, `stack_underflow`=1.
   - `clr_err` -> both flags 0.
5. Wrap and priority:
   - Branch to FFFF, then increment -> 0000.
   - Branch to FFFF, then call to 2000 with `ret_en`=0 -> pushed address 0000.
   - `ret_en`, `call_en` and `branch_en` all high -> return wins, PC 0000.
6. Count 2 and PC 1234, drive `rst`=0 between clock edges -> PC 0000, count 0, flags 0 immediately without waiting for an edge. A following return sets `stack_underflow`.
